// File: rtl/uart_pkg.sv
// Shared UART definitions: bit-timing helpers (also used by the TX path), frame width, RX states.
// Pure declarations; no latency, no backpressure.
package uart_pkg;

    localparam int DataBits = 8;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_BREAK
    } rx_state_e;

    function automatic int clocks_per_bit(input int clock_hz, input int baud);
        return clock_hz / baud;
    endfunction

    function automatic int half_bit(input int clock_hz, input int baud);
        return clocks_per_bit(clock_hz, baud) / 2;
    endfunction

endpackage

// File: rtl/uart_rx_synchronizer.sv
// Two-flop synchronizer for the asynchronous RX pin; resets to the idle (high) level.
// Latency 2 clocks; no backpressure.
module uart_rx_synchronizer (
    input  logic clock,
    input  logic reset,
    input  logic rx_i,
    output logic rx_sync_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= rx_i;
            sync_q <= meta_q;
        end
    end

    assign rx_sync_o = sync_q;

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: mid-bit sampling, one-cycle dataValid / framingError strobes.
// Strobe lands HalfBit + 9*ClocksPerBit edges after IDLE sees the start bit; no backpressure.
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int ClockFrequency = 1000000,
    parameter int BaudRate       = 9600
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                rx,
    output logic [DataBits-1:0] data,
    output logic                dataValid,
    output logic                framingError,
    output logic                busy
);

    localparam int ClocksPerBit = clocks_per_bit(ClockFrequency, BaudRate);
    localparam int HalfBit      = half_bit(ClockFrequency, BaudRate);
    localparam int CntW         = $clog2(ClocksPerBit);
    localparam int IdxW         = $clog2(DataBits);

    localparam logic [CntW-1:0] HalfLast = CntW'(HalfBit - 1);
    localparam logic [CntW-1:0] BitLast  = CntW'(ClocksPerBit - 1);
    localparam logic [IdxW-1:0] IdxLast  = IdxW'(DataBits - 1);

    if (ClocksPerBit < 4) begin : g_cpb_check
        $error("uart_rx_byte: ClocksPerBit must be at least 4");
    end

    logic rx_sync;

    uart_rx_synchronizer u_sync (
        .clock     (clock),
        .reset     (reset),
        .rx_i      (rx),
        .rx_sync_o (rx_sync)
    );

    rx_state_e           state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic [DataBits-1:0] shift_q, shift_d;
    logic [DataBits-1:0] data_q, data_d;
    logic                valid_q, valid_d;
    logic                ferr_q, ferr_d;
    logic                busy_q, busy_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;

        unique case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (!rx_sync) begin
                    state_d = RX_START;
                end
            end
            RX_START: begin
                if (cnt_q == HalfLast) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    // A start bit that is high again at mid-bit was only a glitch.
                    state_d = rx_sync ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_q == BitLast) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_sync;
                    idx_d          = idx_q + 1'b1;
                    if (idx_q == IdxLast) begin
                        state_d = RX_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_q == BitLast) begin
                    cnt_d = '0;
                    if (rx_sync) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = RX_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = RX_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_BREAK: begin
                // Hold here until the line idles so a stuck-low line yields one error only.
                if (rx_sync) begin
                    state_d = RX_IDLE;
                end
            end
            default: begin
                state_d = RX_IDLE;
            end
        endcase
    end

    // Registered busy: rises one edge after leaving IDLE, falls on the edge that returns to it.
    assign busy_d = (state_q != RX_IDLE) && (state_d != RX_IDLE);

    assign data         = data_q;
    assign dataValid    = valid_q;
    assign framingError = ferr_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte at 104 clocks per bit; strobes are logged at negedge with their cycle.
module tb_uart_rx_byte;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       rx    = 1'b1;
    logic [7:0] data;
    logic       dataValid;
    logic       framingError;
    logic       busy;

    int n_vec    = 0;
    int n_err    = 0;
    int cyc      = 0;
    int both_cnt = 0;

    int         ev_cyc[$];
    logic [7:0] ev_dat[$];
    logic       ev_fe[$];

    uart_rx_byte #(
        .ClockFrequency (1000000),
        .BaudRate       (9600)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .rx           (rx),
        .data         (data),
        .dataValid    (dataValid),
        .framingError (framingError),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (dataValid || framingError) begin
            ev_cyc.push_back(cyc);
            ev_dat.push_back(data);
            ev_fe.push_back(framingError);
        end
        if (dataValid && framingError) both_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_neg(input int n);
        while (cyc < n) @(negedge clock);
    endtask

    // Frame starts at #1 after a posedge; returns one edge short of the stop-bit end so
    // a following call continues back-to-back.
    task automatic send_frame(input logic [7:0] b, input int cpb, input logic stop_bit,
                              output int t0);
        @(posedge clock);
        #1;
        rx = 1'b0;
        t0 = cyc;
        for (int i = 0; i < 8; i++) begin
            repeat (cpb) @(posedge clock);
            #1;
            rx = b[i];
        end
        repeat (cpb) @(posedge clock);
        #1;
        rx = stop_bit;
        repeat (cpb - 1) @(posedge clock);
    endtask

    task automatic expect_byte(input string tag, input int base, input logic [7:0] exp_dat);
        chk_eq({tag, "_count"}, ev_cyc.size() - base, 1);
        if (ev_cyc.size() > base) begin
            chk_eq({tag, "_data"}, ev_dat[base], exp_dat);
            chk_eq({tag, "_kind"}, ev_fe[base], 1'b0);
        end
    endtask

    initial begin
        int t, t1, t2, base, dummy;

        repeat (3) @(negedge clock);
        chk_eq("rst_data", data, 8'h00);
        chk_eq("rst_valid", dataValid, 1'b0);
        chk_eq("rst_ferr", framingError, 1'b0);
        chk_eq("rst_busy", busy, 1'b0);
        reset = 1'b1;
        repeat (5) @(negedge clock);

        // Single good frame
        base = ev_cyc.size();
        send_frame(8'hA5, 104, 1'b1, t);
        repeat (100) @(negedge clock);
        expect_byte("a5", base, 8'hA5);
        if (ev_cyc.size() > base) chk_eq("a5_cycle", ev_cyc[base], t + 991);
        chk_eq("a5_busy_idle", busy, 1'b0);
        chk_eq("a5_data_hold", data, 8'hA5);

        // Back-to-back frames, no idle gap
        base = ev_cyc.size();
        send_frame(8'h00, 104, 1'b1, t1);
        send_frame(8'hFF, 104, 1'b1, t2);
        repeat (100) @(negedge clock);
        chk_eq("b2b_count", ev_cyc.size() - base, 2);
        if (ev_cyc.size() > base + 1) begin
            chk_eq("b2b_first_cycle", ev_cyc[base], t1 + 991);
            chk_eq("b2b_spacing", ev_cyc[base + 1] - ev_cyc[base], 1040);
            chk_eq("b2b_data0", ev_dat[base], 8'h00);
            chk_eq("b2b_data1", ev_dat[base + 1], 8'hFF);
        end

        // 20-clock glitch
        base = ev_cyc.size();
        @(posedge clock);
        #1;
        rx = 1'b0;
        t = cyc;
        wait_neg(t + 3);
        chk_eq("glitch_busy_e0", busy, 1'b0);
        wait_neg(t + 4);
        chk_eq("glitch_busy_e1", busy, 1'b1);
        wait_neg(t + 19);
        @(posedge clock);
        #1;
        rx = 1'b1;
        wait_neg(t + 54);
        chk_eq("glitch_busy_e51", busy, 1'b1);
        wait_neg(t + 55);
        chk_eq("glitch_busy_e52", busy, 1'b0);
        repeat (1100) @(negedge clock);
        chk_eq("glitch_no_strobe", ev_cyc.size() - base, 0);

        // Framing error, then line held low
        base = ev_cyc.size();
        send_frame(8'h3C, 104, 1'b0, t);
        repeat (3000) @(posedge clock);
        @(negedge clock);
        chk_eq("ferr_busy_held", busy, 1'b1);
        chk_eq("ferr_data_kept", data, 8'hFF);
        chk_eq("ferr_count", ev_cyc.size() - base, 1);
        if (ev_cyc.size() > base) begin
            chk_eq("ferr_kind", ev_fe[base], 1'b1);
            chk_eq("ferr_cycle", ev_cyc[base], t + 991);
        end
        @(posedge clock);
        #1;
        rx = 1'b1;
        t = cyc;
        wait_neg(t + 5);
        chk_eq("ferr_busy_release", busy, 1'b0);
        repeat (50) @(negedge clock);
        base = ev_cyc.size();
        send_frame(8'h3C, 104, 1'b1, t);
        repeat (100) @(negedge clock);
        expect_byte("ferr_recover", base, 8'h3C);

        // Reset during data bit 4 (0xF0: remaining bits high, so no new falling edge)
        base = ev_cyc.size();
        fork
            send_frame(8'hF0, 104, 1'b1, dummy);
            begin
                repeat (570) @(negedge clock);
                chk_eq("mid_busy_pre", busy, 1'b1);
                reset = 1'b0;
                #1;
                chk_eq("mid_rst_data", data, 8'h00);
                chk_eq("mid_rst_valid", dataValid, 1'b0);
                chk_eq("mid_rst_ferr", framingError, 1'b0);
                chk_eq("mid_rst_busy", busy, 1'b0);
                repeat (3) @(negedge clock);
                reset = 1'b1;
            end
        join
        repeat (100) @(negedge clock);
        chk_eq("mid_no_strobe", ev_cyc.size() - base, 0);
        chk_eq("mid_busy_after", busy, 1'b0);
        base = ev_cyc.size();
        send_frame(8'h5A, 104, 1'b1, t);
        repeat (100) @(negedge clock);
        expect_byte("after_rst", base, 8'h5A);

        // Baud mismatch in both directions
        base = ev_cyc.size();
        send_frame(8'h96, 100, 1'b1, t);
        repeat (60) @(negedge clock);
        expect_byte("slow_cpb100", base, 8'h96);
        base = ev_cyc.size();
        send_frame(8'h96, 108, 1'b1, t);
        repeat (60) @(negedge clock);
        expect_byte("fast_cpb108", base, 8'h96);

        chk_eq("strobe_exclusive", both_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
